// File: rtl/feed_pkg.sv
// Shared types and default sizes for the feeder pop scheduler.
package feed_pkg;

    localparam int unsigned N_LANES_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        RUN,
        DRAIN,
        DONE
    } feed_sched_state_e;

endpackage

// File: rtl/feed_pop_scheduler_if.sv
// Control bus between the global controller and the feeder pop scheduler.
interface feed_pop_scheduler_if #(
    parameter int unsigned N_LANES = feed_pkg::N_LANES_DEF,
    parameter int unsigned CNT_W   = feed_pkg::CNT_W_DEF
);

    logic               i_start;
    logic [CNT_W-1:0]   i_pop_cnt;
    logic               i_pipeline_en;
    logic               i_clearfifo;
    logic [N_LANES-1:0] i_fifo_empty;
    logic [N_LANES-1:0] o_pop_en;
    logic               o_busy;
    logic               o_done;
    logic               o_stall_req;

    modport master (
        output i_start, i_pop_cnt, i_pipeline_en, i_clearfifo, i_fifo_empty,
        input  o_pop_en, o_busy, o_done, o_stall_req
    );

    modport slave (
        input  i_start, i_pop_cnt, i_pipeline_en, i_clearfifo, i_fifo_empty,
        output o_pop_en, o_busy, o_done, o_stall_req
    );

endinterface

// File: rtl/feed_skew_sreg.sv
// Enable-gated shift register producing a staggered (one step per lane) control vector.
module feed_skew_sreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q
);

    // Shift toward higher lanes on each enabled cycle; clear wins over enable.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_q <= '0;
        end else if (i_clr) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= WIDTH'({o_q, i_din});
        end
    end

endmodule

// File: rtl/feed_pop_scheduler.sv
// Skewed per-lane pop-enable generator feeding the systolic-array X/Y FIFOs.
module feed_pop_scheduler
    import feed_pkg::*;
#(
    parameter int unsigned N_LANES = N_LANES_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    feed_pop_scheduler_if.slave  bus
);

    feed_sched_state_e  state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [CNT_W-1:0]   lat_q, lat_n;
    logic               busy_q, done_q;
    logic [N_LANES-1:0] sr;

    // Lane 0 is fed by RUN; the other lanes follow one enabled cycle apart.
    feed_skew_sreg #(.WIDTH(N_LANES)) u_skew (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_en   (bus.i_pipeline_en),
        .i_clr  (bus.i_clearfifo),
        .i_din  (state_q == RUN),
        .o_q    (sr)
    );

    // State, pop counter, latched tile count and registered status flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            lat_q   <= lat_n;
            busy_q  <= (state_n != IDLE);
            done_q  <= (state_n == DONE);
        end
    end

    // Next-state logic; everything holds while the pipeline is disabled except the
    // WAIT_FILL exit and the single-cycle DONE state.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        lat_n   = lat_q;
        if (bus.i_clearfifo) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_start && bus.i_pipeline_en) begin
                        if (bus.i_pop_cnt != '0) begin
                            lat_n   = bus.i_pop_cnt;
                            state_n = WAIT_FILL;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
                WAIT_FILL: begin
                    if (!bus.i_fifo_empty[0]) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (bus.i_pipeline_en) begin
                        if (cnt_q == lat_q - CNT_W'(1)) begin
                            cnt_n   = '0;
                            state_n = DRAIN;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.i_pipeline_en && (sr == '0)) begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.o_pop_en    = sr;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    // Advisory stall: an enabled lane is about to pop an empty FIFO.
    assign bus.o_stall_req = |(sr & bus.i_fifo_empty);

endmodule

// File: tb/tb_feed_pop_scheduler.sv
// Self-checking bench for feed_pop_scheduler: directed scenarios plus randomized traffic
// against a tick-count reference model.
module tb_feed_pop_scheduler;

    localparam int unsigned NL = 4;
    localparam int unsigned CW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    feed_pop_scheduler_if #(.N_LANES(NL), .CNT_W(CW)) bus ();

    feed_pop_scheduler #(.N_LANES(NL), .CNT_W(CW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a tile is a count of enabled ticks since RUN began.
    // Lane k pops on ticks k+1 .. k+lat; the tile completes on tick lat+NL+1.
    typedef enum int {M_IDLE, M_FILL, M_ACT, M_DONE} phase_e;
    phase_e ph   = M_IDLE;
    int     tick = 0;
    int     lat  = 0;

    int pops_seen [NL];
    int done_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] model_pop();
        logic [NL-1:0] v;
        v = '0;
        for (int k = 0; k < NL; k++) begin
            if (ph == M_ACT && tick >= k + 1 && tick <= k + lat) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        ph   = M_IDLE;
        tick = 0;
    endtask

    task automatic model_advance();
        if (bus.i_clearfifo) begin
            ph   = M_IDLE;
            tick = 0;
        end else begin
            case (ph)
                M_IDLE: if (bus.i_start && bus.i_pipeline_en) begin
                    if (bus.i_pop_cnt != '0) begin
                        lat = int'(bus.i_pop_cnt);
                        ph  = M_FILL;
                    end else begin
                        ph = M_DONE;
                    end
                end
                M_FILL: if (!bus.i_fifo_empty[0]) begin
                    ph   = M_ACT;
                    tick = 0;
                end
                M_ACT: if (bus.i_pipeline_en) begin
                    tick++;
                    if (tick == lat + NL + 1) ph = M_DONE;
                end
                default: ph = M_IDLE;
            endcase
        end
    endtask

    task automatic clear_tally();
        for (int k = 0; k < NL; k++) pops_seen[k] = 0;
        done_seen = 0;
    endtask

    // One clock: drive inputs at the falling edge, check outputs, advance the model.
    task automatic cyc(input logic st, input logic [CW-1:0] cnt, input logic en,
                       input logic clr, input logic [NL-1:0] emp);
        logic [NL-1:0] exp_pop;
        @(negedge clk);
        bus.i_start       = st;
        bus.i_pop_cnt     = cnt;
        bus.i_pipeline_en = en;
        bus.i_clearfifo   = clr;
        bus.i_fifo_empty  = emp;
        #1;
        exp_pop = model_pop();
        check_val("pop_en", 32'(bus.o_pop_en), 32'(exp_pop));
        check_val("busy", 32'(bus.o_busy), 32'(ph != M_IDLE));
        check_val("done", 32'(bus.o_done), 32'(ph == M_DONE));
        check_val("stall_req", 32'(bus.o_stall_req), 32'(|(exp_pop & emp)));
        for (int k = 0; k < NL; k++) begin
            if (bus.o_pop_en[k] && en) pops_seen[k]++;
        end
        if (bus.o_done) done_seen++;
        model_advance();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic check_tally(input string tag, input int exp_pops, input int exp_done);
        for (int k = 0; k < NL; k++) check_val({tag, "_pops"}, 32'(pops_seen[k]), 32'(exp_pops));
        check_val({tag, "_done_cnt"}, 32'(done_seen), 32'(exp_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pop_en"}, 32'(bus.o_pop_en), 32'h0);
        check_val({tag, "_busy"}, 32'(bus.o_busy), 32'h0);
        check_val({tag, "_done"}, 32'(bus.o_done), 32'h0);
        check_val({tag, "_stall"}, 32'(bus.o_stall_req), 32'h0);
    endtask

    initial begin
        logic [CW-1:0] rcnt;
        logic [NL-1:0] remp;
        int            r;

        bus.i_start       = 1'b0;
        bus.i_pop_cnt     = '0;
        bus.i_pipeline_en = 1'b0;
        bus.i_clearfifo   = 1'b0;
        bus.i_fifo_empty  = '1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Basic tile, pipeline always enabled.
        clear_tally();
        cyc(1'b1, CW'(3), 1'b1, 1'b0, '0);
        idle_cycles(14);
        check_tally("basic", 3, 1);

        // Two-cycle pipeline bubble in the middle of RUN.
        clear_tally();
        cyc(1'b1, CW'(3), 1'b1, 1'b0, '0);
        idle_cycles(3);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0);
        idle_cycles(14);
        check_tally("bubble", 3, 1);

        // Zero-length tile.
        clear_tally();
        cyc(1'b1, CW'(0), 1'b1, 1'b0, '0);
        idle_cycles(5);
        check_tally("zero", 0, 1);

        // Lane 2 empty while it is popping.
        clear_tally();
        cyc(1'b1, CW'(3), 1'b1, 1'b0, '0);
        idle_cycles(4);
        cyc(1'b0, '0, 1'b1, 1'b0, NL'(4));
        cyc(1'b0, '0, 1'b1, 1'b0, NL'(4));
        idle_cycles(12);
        check_tally("stall", 3, 1);

        // Clear in the middle of DRAIN, then a normal tile.
        clear_tally();
        cyc(1'b1, CW'(3), 1'b1, 1'b0, '0);
        idle_cycles(6);
        cyc(1'b1, CW'(2), 1'b1, 1'b1, '0);
        idle_cycles(6);
        check_val("clear_done_cnt", 32'(done_seen), 32'h0);
        clear_tally();
        cyc(1'b1, CW'(3), 1'b1, 1'b0, '0);
        idle_cycles(14);
        check_tally("after_clear", 3, 1);

        // Start while busy is ignored.
        clear_tally();
        cyc(1'b1, CW'(2), 1'b1, 1'b0, '0);
        idle_cycles(2);
        cyc(1'b1, CW'(5), 1'b1, 1'b0, '0);
        idle_cycles(14);
        check_tally("busy_start", 2, 1);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            if (i % 997 == 500) begin
                @(negedge clk);
                rstn = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                model_reset();
                @(negedge clk);
                rstn = 1'b1;
            end
            r = int'($urandom_range(0, 15));
            if (r == 0)      rcnt = '0;
            else if (r < 12) rcnt = CW'($urandom_range(1, 7));
            else             rcnt = CW'($urandom_range(8, 30));
            remp = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
            begin
                logic en;
                logic st;
                en = ($urandom_range(0, 99) < 80);
                st = en && ($urandom_range(0, 7) == 0);
                cyc(st, rcnt, en, ($urandom_range(0, 79) == 0), remp);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
